// File: rtl/phase_accumulator_mc.sv
// Multi-channel DDS phase accumulator: one shared sample-tick divider,
// per-channel Hz-to-step multiply, phase accumulate and offset address output.

module phase_accumulator_lane #(
   parameter int          ACC_W      = 32,
   parameter int          ADDR_W     = 12,
   parameter int          FREQ_W     = 15,
   parameter logic [63:0] STEP_K     = 64'd90071992547,
   parameter int          STEP_SHIFT = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              upd,
   input  logic              clr,
   input  logic [FREQ_W-1:0] freq,
   input  logic [ADDR_W-1:0] off,
   output logic [ADDR_W-1:0] addr
);

   // Wide enough for any 64-bit constant, so the product never truncates.
   localparam int MUL_W = FREQ_W + 64;

   logic [MUL_W-1:0] prod;
   logic [ACC_W-1:0] step;
   logic [ACC_W-1:0] phase;

   assign prod = MUL_W'(freq) * MUL_W'(STEP_K);

   always_ff @(posedge clk) begin
      if (rst)
         step <= '0;
      else
         step <= ACC_W'(prod >> STEP_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (rst)
         phase <= '0;
      else if (tick)
         phase <= clr ? '0 : phase + step;
   end

   // Offset is sampled only here, so changes between ticks are invisible.
   always_ff @(posedge clk) begin
      if (rst)
         addr <= '0;
      else if (upd)
         addr <= phase[ACC_W-1 -: ADDR_W] + off;
   end

endmodule

module phase_accumulator_mc #(
   parameter int          NUM_CH     = 2,
   parameter int          ACC_W      = 32,
   parameter int          ADDR_W     = 12,
   parameter int          FREQ_W     = 15,
   parameter int          CLK_DIV    = 2000,
   parameter logic [63:0] STEP_K     = 64'd90071992547,
   parameter int          STEP_SHIFT = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     sync,
   input  logic [NUM_CH*FREQ_W-1:0] freq_in,
   input  logic [NUM_CH*ADDR_W-1:0] phase_off,
   output logic [NUM_CH*ADDR_W-1:0] addr_out,
   output logic                     addr_valid,
   output logic                     tick_out
);

   localparam int CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int STAGES = 2;

   logic [CNT_W-1:0]                 cnt;
   logic                             wrap;
   logic [STAGES:0]                  vld_pipe;
   logic                             sync_pending;
   logic                             clr;
   logic [NUM_CH-1:0][FREQ_W-1:0]    freq_a;
   logic [NUM_CH-1:0][ADDR_W-1:0]    off_a;
   logic [NUM_CH-1:0][ADDR_W-1:0]    addr_a;

   assign freq_a   = freq_in;
   assign off_a    = phase_off;
   assign addr_out = addr_a;

   assign wrap = en && (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= wrap ? '0 : cnt + 1'b1;
   end

   // [0] tick, [1] phase just updated, [2] address valid
   always_ff @(posedge clk) begin
      if (rst)
         vld_pipe <= '0;
      else
         vld_pipe <= {vld_pipe[STAGES-1:0], wrap};
   end

   assign tick_out   = vld_pipe[0];
   assign addr_valid = vld_pipe[STAGES];

   // A sync seen in the tick cycle itself is consumed directly via clr.
   always_ff @(posedge clk) begin
      if (rst)
         sync_pending <= 1'b0;
      else if (vld_pipe[0])
         sync_pending <= 1'b0;
      else if (sync)
         sync_pending <= 1'b1;
   end

   assign clr = sync_pending | sync;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      phase_accumulator_lane #(
         .ACC_W     (ACC_W),
         .ADDR_W    (ADDR_W),
         .FREQ_W    (FREQ_W),
         .STEP_K    (STEP_K),
         .STEP_SHIFT(STEP_SHIFT)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .tick(vld_pipe[0]),
         .upd (vld_pipe[1]),
         .clr (clr),
         .freq(freq_a[c]),
         .off (off_a[c]),
         .addr(addr_a[c])
      );
   end

endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Bench for phase_accumulator_mc: directed divider/sync/gating/reset cases plus
// randomized frequencies and offsets checked against a per-tick arithmetic model.

module tb_phase_accumulator_mc;

   localparam int NC  = 3;
   localparam int DIV = 4;
   localparam longint unsigned K = 64'd90071992547;

   logic                clk = 1'b0;
   logic                rst, en, sync;
   logic [NC*15-1:0]    freq_in;
   logic [NC*12-1:0]    phase_off;
   logic [NC*12-1:0]    addr_out;
   logic                addr_valid, tick_out;

   int n_chk  = 0;
   int n_fail = 0;

   logic [14:0]      f    [NC];
   logic [11:0]      o    [NC];
   longint unsigned  m_ph [NC];
   bit               pend;

   phase_accumulator_mc #(
      .NUM_CH (NC),
      .CLK_DIV(DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .freq_in   (freq_in),
      .phase_off (phase_off),
      .addr_out  (addr_out),
      .addr_valid(addr_valid),
      .tick_out  (tick_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      for (int c = 0; c < NC; c++) begin
         freq_in[c*15 +: 15]   = f[c];
         phase_off[c*12 +: 12] = o[c];
      end
   endtask

   function automatic longint unsigned stepf(input int c);
      return ((longint'(f[c]) * K) >> 20) & 64'hFFFF_FFFF;
   endfunction

   function automatic longint unsigned exp_addr(input int c);
      return ((m_ph[c] >> 20) + o[c]) % 4096;
   endfunction

   // Waits for the next tick (expected after 'gap' clocks), advances the model,
   // and returns two cycles later with addr_out checked.
   task automatic do_tick(input bit sync_now, input int gap);
      int n = 0;
      do begin
         clk1();
         n++;
      end while (!tick_out && n < 100);
      chk("tick_gap", n, gap);
      if (sync_now) sync = 1'b1;
      if (pend || sync_now) begin
         for (int c = 0; c < NC; c++) m_ph[c] = 0;
         pend = 1'b0;
      end else begin
         for (int c = 0; c < NC; c++) m_ph[c] = (m_ph[c] + stepf(c)) % 64'h1_0000_0000;
      end
      clk1();
      sync = 1'b0;
      chk("tick_1cyc", tick_out, 0);
      chk("av_early", addr_valid, 0);
      clk1();
      chk("av_pulse", addr_valid, 1);
      for (int c = 0; c < NC; c++) chk($sformatf("addr_ch%0d", c), addr_out[c*12 +: 12], exp_addr(c));
   endtask

   initial begin
      int g;
      logic [NC*12-1:0] held;
      rst = 1'b1; en = 1'b0; sync = 1'b0; freq_in = '0; phase_off = '0; pend = 1'b0;
      for (int c = 0; c < NC; c++) begin f[c] = 0; o[c] = 0; m_ph[c] = 0; end

      repeat (3) begin
         clk1();
         chk("rst_tick", tick_out, 0);
         chk("rst_av", addr_valid, 0);
         chk("rst_addr", addr_out, 0);
      end

      rst = 1'b0; en = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         clk1();
         chk("div_tick", tick_out, (i % DIV == 0));
         chk("div_av", addr_valid, (i >= 6 && (i - 2) % DIV == 0));
      end
      chk("div_addr", addr_out, 0);

      // accumulate and wrap; ch2 has zero frequency with a max offset
      f[0] = 1000; f[1] = 1000; f[2] = 0;
      o[0] = 0;    o[1] = 1024; o[2] = 4095;
      apply();
      for (int t = 1; t <= 51; t++) begin
         do_tick(1'b0, (t == 1) ? 3 : 2);
         if (t == 1) begin
            chk("step0", dut.g_ch[0].u_lane.step, 85899345);
            chk("t1_ch0", addr_out[11:0], 81);
            chk("t1_ch1", addr_out[23:12], 1105);
            chk("t1_ch2", addr_out[35:24], 4095);
         end
         if (t == 50) begin
            chk("t50_ph", dut.g_ch[0].u_lane.phase, 64'd4294967250);
            chk("t50_addr", addr_out[11:0], 4095);
         end
         if (t == 51) begin
            chk("t51_ph", dut.g_ch[0].u_lane.phase, 85899299);
            chk("t51_addr", addr_out[11:0], 81);
            chk("t51_ch2", addr_out[35:24], 4095);
         end
      end

      // two sync pulses mid-period (second one while the divider is frozen)
      sync = 1'b1;
      clk1();
      sync = 1'b0; en = 1'b0;
      clk1();
      sync = 1'b1;
      clk1();
      sync = 1'b0; en = 1'b1;
      pend = 1'b1;
      do_tick(1'b0, 1);
      chk("sync_ph0", dut.g_ch[0].u_lane.phase, 0);
      chk("sync_ph1", dut.g_ch[1].u_lane.phase, 0);
      chk("sync_off1", addr_out[23:12], 1024);
      do_tick(1'b0, 2);
      chk("sync_resume", addr_out[11:0], 81);

      // sync coincident with the tick
      do_tick(1'b1, 2);
      chk("sync_tick_ph", dut.g_ch[1].u_lane.phase, 0);

      // enable gap of 7 cycles
      do_tick(1'b0, 2);
      held = addr_out;
      en = 1'b0;
      repeat (7) begin
         clk1();
         chk("gate_tick", tick_out, 0);
      end
      chk("gate_ph", dut.g_ch[0].u_lane.phase, m_ph[0]);
      chk("gate_addr", addr_out, held);
      en = 1'b1;
      do_tick(1'b0, 2);

      // randomized frequencies, offsets and tick-coincident syncs
      g = 2;
      for (int it = 0; it < 30; it++) begin
         for (int c = 0; c < NC; c++) begin
            f[c] = 15'($urandom_range(0, 32767));
            o[c] = 12'($urandom_range(0, 4095));
         end
         if (it % 5 == 0) f[$urandom_range(0, NC - 1)] = 15'h7FFF;
         apply();
         do_tick($urandom_range(0, 5) == 0, g);
         held = addr_out;
         for (int c = 0; c < NC; c++) o[c] = 12'($urandom_range(0, 4095));
         apply();
         clk1();
         chk("off_held", addr_out, held);
         g = 1;
      end

      // reset with a pending sync and the counter at CLK_DIV-2
      do_tick(1'b0, 1);
      en = 1'b0; sync = 1'b1;
      clk1();
      sync = 1'b0;
      chk("pre_rst_pend", dut.sync_pending, 1);
      chk("pre_rst_cnt", dut.cnt, DIV - 2);
      rst = 1'b1;
      clk1();
      en = 1'b1;
      chk("mid_rst_pend", dut.sync_pending, 0);
      chk("mid_rst_ph", dut.g_ch[0].u_lane.phase, 0);
      chk("mid_rst_addr", addr_out, 0);
      clk1();
      chk("mid_rst_tick", tick_out, 0);
      chk("mid_rst_cnt", dut.cnt, 0);
      rst = 1'b0;
      pend = 1'b0;
      for (int c = 0; c < NC; c++) m_ph[c] = 0;
      do_tick(1'b0, DIV);
      do_tick(1'b0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
